// File: rtl/piso_shift_register.sv
// piso_shift_register: 74HC165-style parallel-in/serial-out shift register, MSB-first on q.
// Define PISO_STATUS_EN to add the `empty` output backed by a saturating shift counter.
module piso_shift_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shld,
    input  logic             clk_inh,
    input  logic             ser,
    input  logic [WIDTH-1:0] parin,
    output logic             q,
    output logic             q_n
`ifdef PISO_STATUS_EN
    ,
    output logic             empty
`endif
);

    logic [WIDTH-1:0] r_sr;
    logic             w_load;
    logic             w_shift;

    // Load wins over inhibit; inhibit only freezes shifting.
    assign w_load  = ~shld;
    assign w_shift = shld & ~clk_inh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (w_load) begin
            r_sr <= parin;
        end else if (w_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], ser};
        end
    end

    assign q   = r_sr[WIDTH-1];
    assign q_n = ~r_sr[WIDTH-1];

`ifdef PISO_STATUS_EN
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_empty;

    assign w_cnt_nxt = r_cnt + 1'b1;

    // Counter saturates at WIDTH; empty is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= CNT_FULL;
            r_empty <= 1'b1;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_empty <= 1'b0;
        end else if (w_shift && (r_cnt != CNT_FULL)) begin
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == CNT_FULL);
        end
    end

    assign empty = r_empty;
`endif

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench for piso_shift_register: a driver pushes expected outputs from a
// word-level reference model, and an independent monitor pops and compares them.
module tb_piso_shift_register;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             shld = 1'b1;
    logic             clk_inh = 1'b0;
    logic             ser_drv = 1'b0;
    logic             loopback = 1'b0;
    logic             ser;
    logic [WIDTH-1:0] parin = '0;
    logic             q;
    logic             q_n;
`ifdef PISO_STATUS_EN
    logic             empty;
`endif

    assign ser = loopback ? q : ser_drv;

    piso_shift_register #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .shld    (shld),
        .clk_inh (clk_inh),
        .ser     (ser),
        .parin   (parin)
`ifdef PISO_STATUS_EN
        ,
        .empty   (empty)
`endif
        ,
        .q       (q),
        .q_n     (q_n)
    );

    always #5 clk = ~clk;

    // Reference model: the register as a number plus a count of shifts since the last load.
    longint unsigned m_val;
    int              m_shifts;

    string exp_nm[$];
    logic  exp_qv[$];
    logic  exp_ev[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    logic  chk_tgl = 1'b0;

    string c_nm;
    logic  c_q;
    logic  c_e;

    function automatic logic m_q();
        return logic'((m_val >> (WIDTH - 1)) & 1);
    endfunction

    function automatic void push_exp(input string nm);
        exp_nm.push_back(nm);
        exp_qv.push_back(m_q());
        exp_ev.push_back(m_shifts >= WIDTH);
    endfunction

    function automatic void m_reset();
        m_val    = 0;
        m_shifts = WIDTH;
    endfunction

    // Monitor: compares after every clock edge and after an explicit async-reset probe.
    always begin
        @(posedge clk or chk_tgl);
        #1;
        while (exp_nm.size() > 0) begin
            c_nm = exp_nm.pop_front();
            c_q  = exp_qv.pop_front();
            c_e  = exp_ev.pop_front();
            n_chk++;
            if ({q, q_n} === {c_q, ~c_q}) n_pass++;
            else $display("FAIL %s: q,q_n=%b%b required %b%b at %0t", c_nm, q, q_n, c_q, ~c_q, $time);
`ifdef PISO_STATUS_EN
            n_chk++;
            if (empty === c_e) n_pass++;
            else $display("FAIL %s_empty: empty=%b required %b at %0t", c_nm, empty, c_e, $time);
`endif
        end
    end

    // One clock edge of stimulus; inputs change on the falling edge.
    task automatic step(input logic s, input logic inh, input logic sv,
                        input logic [WIDTH-1:0] p, input string nm);
        logic fill;
        shld    = s;
        clk_inh = inh;
        ser_drv = sv;
        parin   = p;
        fill    = loopback ? m_q() : sv;
        @(posedge clk);
        if (!s) begin
            m_val    = longint'(p);
            m_shifts = 0;
        end else if (!inh) begin
            m_val = (m_val * 2 + longint'(fill)) % (64'd1 << WIDTH);
            if (m_shifts < WIDTH) m_shifts++;
        end
        push_exp(nm);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        // Reset held with the clock running.
        repeat (3) begin
            @(posedge clk);
            push_exp("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Load 15AF and shift out with zero fill.
        step(1'b0, 1'b0, 1'b0, 16'h15AF, "load_15AF");
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, '0, "shift_15AF");

        // Loopback rotate: back to the loaded word after WIDTH shifts.
        step(1'b0, 1'b0, 1'b0, 16'h15AF, "loop_load");
        loopback = 1'b1;
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b0, 1'b0, '0, "loop_rot");
        loopback = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, "post_rot");

        // Inhibit holds, release shifts, load under inhibit still loads.
        step(1'b0, 1'b0, 1'b0, 16'h8000, "inh_load");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, '0, "inh_hold");
        step(1'b1, 1'b0, 1'b0, '0, "inh_release");
        step(1'b0, 1'b1, 1'b0, 16'h0001, "inh_load_0001");
        step(1'b1, 1'b1, 1'b0, '0, "inh_hold2");
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, '0, "shift_0001");

        // Async reset mid-shift, probed between edges.
        step(1'b0, 1'b0, 1'b0, 16'hFFFF, "pre_rst_load");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0, "pre_rst_shift");
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        push_exp("async_rst");
        chk_tgl = ~chk_tgl;
        #2 rst_n = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 16'hFFFF, "post_rst_load");

        // Ones fill from an all-zero word.
        step(1'b0, 1'b0, 1'b0, 16'h0000, "fill_load");
        for (int i = 0; i < WIDTH + 2; i++) step(1'b1, 1'b0, 1'b1, '0, "ones_fill");

        // Repeated load tracks parin one edge late.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 1'b0, WIDTH'($urandom), "reload");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0), ($urandom_range(3) == 0), 1'($urandom),
                 WIDTH'($urandom), "random");
        end

        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_nm.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, required 0", exp_nm.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
# piso_shift_register

Parameterised parallel-in/serial-out shift register modelled on a 74HC165-style part. It captures a WIDTH-bit word on a synchronous load, then shifts it out MSB-first on `q` with complementary `q_n`, taking fill data from `ser`. It sits at the edge of the parts-bin logic library as a serialiser, for example driving a serial link or loopback chain. Loopback is `ser` tied to `q`.

## Interface
Parameters:
- WIDTH, 16, register length in bits; legal values are 2 and up.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- shld  input  1  shift/load select: 0 = load `parin`, 1 = shift.
- clk_inh  input  1  clock inhibit, active-high; freezes shifting only.
- ser  input  1  serial data shifted into bit 0.
- parin  input  WIDTH  parallel load word.
- q  output  1  serial output, equals register bit WIDTH-1.
- q_n  output  1  always the inverse of `q`.
- empty  output  1  present only with PISO_STATUS_EN; see Configuration.

## Operation
- State is a WIDTH-bit register `sr`.
- `q` is `sr[WIDTH-1]` and `q_n` is `~sr[WIDTH-1]`, both purely combinational from `sr`.
- Priority at each rising clk edge, highest first: reset, then load, then inhibit, then shift.
- Reset: `rst_n`=0 immediately clears `sr` to 0, giving `q`=0 and `q_n`=1, independent of clk. Reset may be asserted mid-shift; any partial word is lost.
- Load: `shld`=0 sets `sr` to `parin` at the edge. Load is honoured even when `clk_inh`=1.
- Inhibit: `shld`=1 with `clk_inh`=1 holds `sr` unchanged.
- Shift: `shld`=1 with `clk_inh`=0 sets `sr` to {`sr[WIDTH-2:0]`, `ser`}, so the word leaves MSB-first.
- With `ser` tied to `q`, the register rotates and returns to the loaded word after exactly WIDTH shifts.
- `shld` held low across several edges reloads on every edge; `q` tracks `parin[WIDTH-1]` one edge late.
- No other state exists unless the macro below is defined.

## Timing
- Load latency is 1 edge: `q` = `parin[WIDTH-1]` immediately after the loading edge.
- Each shift edge presents the next lower original bit on `q`; bit k of the loaded word appears after WIDTH-1-k shift edges.
- Reset assertion is asynchronous. Deassertion is taken synchronously by the design user; the first edge with `rst_n`=1 acts normally.
- Inputs must meet setup and hold to clk. There is no handshake.

## Configuration
- PISO_STATUS_EN, when defined, adds the `empty` output and a saturating shift counter sized $clog2(WIDTH+1).
  - Reset sets the counter to WIDTH, so `empty`=1.
  - A load clears the counter to 0, so `empty`=0.
  - Each effective shift (not inhibited) increments the counter, saturating at WIDTH.
  - `empty`=1 when the counter equals WIDTH. It is registered and asserts on the edge of the WIDTH-th shift.
  - Load has priority over counting. Inhibited edges do not count.
- When PISO_STATUS_EN is undefined, the `empty` port and the counter do not exist, and the behaviour is otherwise identical.

## Test plan
- Reset: hold `rst_n`=0 with clk running -> `q`=0, `q_n`=1; with the macro, `empty`=1.
- Load and shift out, WIDTH=16: load `parin`=16'h15AF, then shift 15 edges with `ser`=0. Required `q` sequence starting right after the load: 0,0,0,1,0,1,0,1,1,0,1,0,1,1,1,1. `q_n` is always the inverse.
- Loopback rotate: `ser`=`q`, load 16'h15AF, shift 16 edges -> `sr`=16'h15AF and `q`=0 again. With the macro, `empty` rises on the 16th shift.
- Inhibit: after loading 16'h8000, set `clk_inh`=1 for 5 edges -> `q` stays 1. Release -> `q`=0 on the next edge. A load during inhibit of 16'h0001 still takes effect.
- Async reset mid-shift: after 7 shifts, pulse `rst_n` low between edges -> `q`=0 immediately without waiting for a clock edge. The next load of 16'hFFFF gives `q`=1.
- Ones fill: load 16'h0000 and shift with `ser`=1 -> `q` becomes 1 on the 16th shift edge.
